// File: rtl/measure_display.sv
// Throttled 14-bit measurement readout for six active-low seven-segment digits.
// Samples periodically, converts with iterative double-dabble, blanks leading zeros.
module measure_display #(
   parameter int REFRESH_CYCLES = 5_000_000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [13:0] num,
   input  logic [2:0]  measurement,
   input  logic        hold,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic        busy,
   output logic        update
);

   localparam int CW = $clog2(REFRESH_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);
   localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [33:0]     sr_q, sr_d, sr_adj;
   logic [2:0]      mode_q, mode_d;
   logic [3:0]      bit_q, bit_d;
   logic [5:0][6:0] hex_q, hex_d;
   logic            upd_q, upd_d;
   logic            tick;
   logic [4:0][6:0] dig_hex;
   logic [3:0]      dig;
   logic            seen;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   assign tick = (cnt_q == LAST);

   // Walk from the top digit down; a digit shows once any higher one was non-zero.
   always_comb begin
      seen    = 1'b0;
      dig     = 4'd0;
      dig_hex = '0;
      for (int i = 4; i >= 0; i--) begin
         dig        = sr_q[14+4*i +: 4];
         seen       = seen | (dig != 4'd0) | (i == 0);
         dig_hex[i] = seen ? seg7(dig) : 7'h7F;
      end
   end

   always_comb begin
      sr_adj = sr_q;
      for (int i = 0; i < 5; i++) begin
         if (sr_q[14+4*i +: 4] >= 4'd5)
            sr_adj[14+4*i +: 4] = sr_q[14+4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      mode_d  = mode_q;
      bit_d   = bit_q;
      hex_d   = hex_q;
      upd_d   = 1'b0;
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      unique case (state_q)
         IDLE: begin
            if (tick && !hold) begin
               sr_d    = {20'd0, num};
               mode_d  = measurement;
               bit_d   = 4'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            sr_d  = {sr_adj[32:0], 1'b0};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd13)
               state_d = DONE;
         end
         DONE: begin
            upd_d   = 1'b1;
            state_d = IDLE;
            case (mode_q)
               3'd1:    hex_d = {7'h07, dig_hex};
               3'd2:    hex_d = {7'h41, dig_hex};
               default: hex_d = ALL_BLANK;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         mode_q  <= '0;
         bit_q   <= '0;
         hex_q   <= ALL_BLANK;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         mode_q  <= mode_d;
         bit_q   <= bit_d;
         hex_q   <= hex_d;
         upd_q   <= upd_d;
      end
   end

   assign HEX0   = hex_q[0];
   assign HEX1   = hex_q[1];
   assign HEX2   = hex_q[2];
   assign HEX3   = hex_q[3];
   assign HEX4   = hex_q[4];
   assign HEX5   = hex_q[5];
   assign busy   = (state_q != IDLE);
   assign update = upd_q;

endmodule

// File: tb/tb_measure_display.sv
// Bench for measure_display: two instances (refresh 20 and 2) against a
// decimal-arithmetic model with a 15-edge publish delay.
module tb_measure_display;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [13:0] num_v [2];
   logic [2:0]  meas_v [2];
   logic        hold_v [2];
   logic [6:0]  h0 [2], h1 [2], h2 [2], h3 [2], h4 [2], h5 [2];
   logic        busy_o [2];
   logic        upd_o [2];
   logic [41:0] hx [2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   measure_display #(.REFRESH_CYCLES(20)) dut (
      .clock(clk), .resetn(resetn), .num(num_v[0]),
      .measurement(meas_v[0]), .hold(hold_v[0]),
      .HEX0(h0[0]), .HEX1(h1[0]), .HEX2(h2[0]),
      .HEX3(h3[0]), .HEX4(h4[0]), .HEX5(h5[0]),
      .busy(busy_o[0]), .update(upd_o[0])
   );

   measure_display #(.REFRESH_CYCLES(2)) dut2 (
      .clock(clk), .resetn(resetn), .num(num_v[1]),
      .measurement(meas_v[1]), .hold(hold_v[1]),
      .HEX0(h0[1]), .HEX1(h1[1]), .HEX2(h2[1]),
      .HEX3(h3[1]), .HEX4(h4[1]), .HEX5(h5[1]),
      .busy(busy_o[1]), .update(upd_o[1])
   );

   assign hx[0] = {h5[0], h4[0], h3[0], h2[0], h1[0], h0[0]};
   assign hx[1] = {h5[1], h4[1], h3[1], h2[1], h1[1], h0[1]};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] tb_seg(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         default: return 7'h10;
      endcase
   endfunction

   function automatic logic [41:0] render(input int n, input int m);
      logic [41:0] r;
      int p;
      if (m != 1 && m != 2) return {6{7'h7F}};
      r = '0;
      r[41:35] = (m == 1) ? 7'h07 : 7'h41;
      p = 1;
      for (int i = 0; i < 5; i++) begin
         r[7*i +: 7] = (i == 0 || n >= p) ? tb_seg((n / p) % 10) : 7'h7F;
         p = p * 10;
      end
      return r;
   endfunction

   // Model: capture on every R-th edge since reset when idle and not held,
   // publish 15 edges later.
   int          k [2];
   int          left [2];
   int          cn [2];
   int          cm [2];
   logic [41:0] ehex [2];
   logic        eupd [2];
   logic        ebusy [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!resetn) begin
            k[d] = 0;
            left[d] = 0;
            ehex[d] = {6{7'h7F}};
            eupd[d] = 1'b0;
         end else begin
            k[d]++;
            eupd[d] = 1'b0;
            if (left[d] > 0) begin
               left[d]--;
               if (left[d] == 0) begin
                  ehex[d] = render(cn[d], cm[d]);
                  eupd[d] = 1'b1;
               end
            end else if (k[d] % (d == 0 ? 20 : 2) == 0 && !hold_v[d]) begin
               cn[d] = int'(num_v[d]);
               cm[d] = int'(meas_v[d]);
               left[d] = 15;
            end
         end
         ebusy[d] = (left[d] > 0);
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("hex%0d", d), 64'(hx[d]), 64'(ehex[d]));
         chk($sformatf("busy%0d", d), 64'(busy_o[d]), 64'(ebusy[d]));
         chk($sformatf("upd%0d", d), 64'(upd_o[d]), 64'(eupd[d]));
      end
   end

   // Fast instance: random inputs, hold low, update spacing of 16 or 17.
   int cyc = 0;
   int last_upd = -1;
   always @(negedge clk) begin
      cyc++;
      if ($urandom % 4 == 0) num_v[1] <= 14'($urandom);
      if ($urandom % 8 == 0) meas_v[1] <= 3'($urandom_range(0, 7));
      if (!resetn) last_upd = -1;
      else if (upd_o[1] === 1'b1) begin
         if (last_upd >= 0)
            chk("gap2", 64'((cyc - last_upd == 16) || (cyc - last_upd == 17)), 64'd1);
         last_upd = cyc;
      end
   end

   task automatic wait_upd(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (upd_o[0] !== 1'b1 && n < 200);
      chk("wait_upd", 64'(upd_o[0]), 64'd1);
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy_o[0] !== 1'b1 && n < 200);
      chk("wait_busy", 64'(busy_o[0]), 64'd1);
   endtask

   task automatic show(input int n, input int m);
      num_v[0] = 14'(n);
      meas_v[0] = 3'(m);
   endtask

   initial begin
      int n;
      int pulses;
      logic [2:0] m;
      num_v[0] = 14'd1234; meas_v[0] = 3'd2; hold_v[0] = 1'b0;
      num_v[1] = 14'd0;    meas_v[1] = 3'd1; hold_v[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hex", 64'(hx[0]), 64'h3FFFFFFFFFF);
      chk("rst_busy", 64'(busy_o[0]), 64'd0);
      chk("rst_upd", 64'(upd_o[0]), 64'd0);
      resetn = 1'b1;

      wait_upd(n);
      chk("first_latency", 64'(n), 64'd35);
      chk("v1234", 64'(hx[0]), {22'd0, 7'h41, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
      show(16383, 1);
      @(negedge clk);
      chk("upd_single", 64'(upd_o[0]), 64'd0);
      wait_upd(n);
      chk("v16383", 64'(hx[0]), {22'd0, 7'h07, 7'h79, 7'h02, 7'h30, 7'h00, 7'h30});
      show(0, 1);
      wait_upd(n);
      chk("v0", 64'(hx[0]), {22'd0, 7'h07, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      show(7, 1);
      wait_upd(n);
      chk("v7", 64'(hx[0]), {22'd0, 7'h07, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});
      show(500, 0);
      wait_upd(n);
      chk("mode0", 64'(hx[0]), 64'h3FFFFFFFFFF);

      show(42, 2);
      wait_upd(n);
      chk("v42", 64'(hx[0]), {22'd0, 7'h41, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
      hold_v[0] = 1'b1;
      show(99, 2);
      pulses = 0;
      repeat (60) begin
         @(negedge clk);
         if (upd_o[0] === 1'b1) pulses++;
      end
      chk("hold_pulses", 64'(pulses), 64'd0);
      chk("hold_v42", 64'(hx[0]), {22'd0, 7'h41, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
      hold_v[0] = 1'b0;
      wait_upd(n);
      chk("v99", 64'(hx[0]), {22'd0, 7'h41, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10});

      show(321, 2);
      wait_busy(n);
      num_v[0] = 14'd555;
      wait_upd(n);
      chk("conv_latency", 64'(n), 64'd15);
      chk("v321", 64'(hx[0]), {22'd0, 7'h41, 7'h7F, 7'h7F, 7'h30, 7'h24, 7'h79});

      show(4321, 1);
      wait_busy(n);
      repeat (6) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("midrst_hex", 64'(hx[0]), 64'h3FFFFFFFFFF);
      chk("midrst_busy", 64'(busy_o[0]), 64'd0);
      resetn = 1'b1;

      repeat (3000) begin
         @(negedge clk);
         if ($urandom % 16 == 0) begin
            m = ($urandom % 4 == 0) ? 3'($urandom_range(0, 7))
                                    : 3'($urandom_range(1, 2));
            show(int'($urandom % 16384), int'(m));
         end
         if ($urandom % 32 == 0) hold_v[0] = ($urandom % 5 == 0);
      end
      hold_v[0] = 1'b0;
      repeat (40) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/measure_display.md
# measure_display

Converts the 14-bit measurement result from the cursor measurement stage into active-low seven-segment patterns for the DE1-SoC HEX0–HEX5 displays. Each refresh period it samples the result and the measurement mode, then converts the value to five BCD digits with a 14-cycle iterative double-dabble. It then drives HEX4..HEX0 with leading-zero blanking and HEX5 with a mode letter. Throttled refresh keeps a jittery measurement readable.

## Interface
- REFRESH_CYCLES, 5_000_000, clock cycles between samples (10 Hz at 50 MHz); legal range ≥ 2.
- clock  input  1  system clock (50 MHz).
- resetn  input  1  synchronous, active-low reset.
- num  input  14  unsigned measurement result, 0..16383.
- measurement  input  3  0 = none, 1 = cursor x (time), 2 = cursor y (voltage), 3..7 = none.
- hold  input  1  freeze display; high suppresses new samples.
- HEX0..HEX5  output  7 each  segment drives, active-low, bit0 = a … bit6 = g; HEX0 is the least significant digit.
- busy  output  1  high while a conversion is in progress (CONV or DONE).
- update  output  1  one-cycle pulse when the HEX outputs take new values.

## Operation
- Refresh counter: free-running, 0..REFRESH_CYCLES-1, wraps to 0. `tick` is asserted on the cycle the counter equals REFRESH_CYCLES-1. The counter is never stalled by busy or hold.
- FSM states:
  - IDLE: on `tick && !hold`, latch num into the low 14 bits of a 34-bit shift register (20 BCD bits zeroed), latch measurement, clear the bit counter, and go to CONV.
  - CONV: each cycle, first add 3 to every BCD nibble ≥ 5, then shift the whole register left by 1. After the 14th shift go to DONE.
  - DONE: register the display outputs, pulse update, and return to IDLE.
- A tick arriving in CONV or DONE is ignored (sample dropped, no queueing).
- Hold does not abort a conversion in progress. It only blocks the start of a new one, and the outputs keep their last values.
- Digit encoding (active-low hex):
  - 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19
  - 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10
  - blank = 0x7F
- Leading-zero blanking: every digit above the most significant non-zero digit is blanked. A value of 0 shows 0x40 on HEX0 with HEX1..HEX4 blank.
- HEX5 shows the mode latched at capture: 1 → 't' (0x07), 2 → 'U' (0x41), otherwise blank.
- Latched measurement 0 or ≥ 3: HEX0..HEX5 are all blank (0x7F), and update still pulses.
- Arithmetic: 14-bit input maps to 5 BCD digits, so there is no overflow. The maximum value 16383 shows all five digits.
- num and measurement are sampled only at capture. Changes during CONV have no effect on that conversion.

## Timing
- Reset values: HEX0..HEX5 = 0x7F, busy = 0, update = 0, state IDLE, refresh counter 0, shift register 0.
- Cycle-level sequence, where edge E0 is the IDLE edge with `tick && !hold` (capture):
  - E0 (capture): busy goes high after E0.
  - E1..E14: the 14 CONV shifts.
  - E15 (DONE): HEX outputs change, update is high for the one cycle following E15, and busy falls after E15.
- Latency: 15 clocks from capture edge to new display values. FSM is back in IDLE after E15, so the next capture is possible at E16 at the earliest.
- First capture after reset occurs at the REFRESH_CYCLES-th edge after resetn deasserts.
- resetn low at any edge, including mid-CONV, applies the reset values on that edge. A partial conversion is never published.
- Simultaneous tick and hold high: hold wins, no capture.

## Test plan
- REFRESH_CYCLES = 20, num = 1234, measurement = 2 → after the first capture plus 15 clocks: HEX3..HEX0 = 0x79, 0x24, 0x30, 0x19; HEX4 = 0x7F; HEX5 = 0x41; update is a single-cycle pulse.
- num = 16383, measurement = 1 → HEX4..HEX0 = 0x79, 0x02, 0x30, 0x00, 0x30; HEX5 = 0x07.
- num = 0, measurement = 1, then num = 7 → HEX0 = 0x40 with HEX1..HEX4 blank; next refresh HEX0 = 0x78; HEX5 = 0x07 throughout.
- measurement = 0, num = 500 → all six HEX = 0x7F after the conversion, and update still pulses.
- Hold: raise hold, change num from 42 to 99 across three refresh periods → outputs stay at the 42 pattern, no update pulses. Release hold → 99 is shown after the next tick + 15 clocks.
- Mid-operation disturbances:
  - Pull resetn low at E7 → all HEX = 0x7F, busy = 0.
  - Change num during CONV → the captured value is displayed, not the changed one.
  - REFRESH_CYCLES = 2 → ticks during busy are dropped and updates occur every 16 or 17 cycles.
